reg_cmd_ctrl: RTL



---
 rtl/reg_cmd_ctrl_pkg.sv | 35 +++
 rtl/reg_cmd_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/reg_cmd_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// reg_cmd_ctrl_pkg
// Shared UART-side definitions for the register command controller:
//   DATA_WIDTH     - byte width of RX/TX and register data
//   ADDRESS_WIDTH  - register-file address width
//   CMD_WRITE      - frame header byte for a register write (0xAA)
//   CMD_READ       - frame header byte for a register read  (0xBB)
//   reg_cmd_state_e - sequencer states
//   addrByteOk()   - checks that an address byte has no bits above the
//                    register-file address range
// ---------------------------------------------------------------------------
package reg_cmd_ctrl_pkg;

  localparam int DATA_WIDTH    = 8;
  localparam int ADDRESS_WIDTH = 4;

  localparam logic [DATA_WIDTH-1:0] CMD_WRITE = 8'hAA;
  localparam logic [DATA_WIDTH-1:0] CMD_READ  = 8'hBB;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    RD_WAIT = 3'd4,
    TX_SEND = 3'd5
  } reg_cmd_state_e;

  // An address byte is only legal when every bit above the register-file
  // address range is zero; anything else would silently alias a register.
  function automatic logic addrByteOk(input logic [DATA_WIDTH-1:0] rxByte);
    return (rxByte[DATA_WIDTH-1:ADDRESS_WIDTH] == '0);
  endfunction

endpackage

// File: rtl/reg_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// reg_cmd_ctrl
// Command decoder/sequencer between the UART RX/TX and the register file.
// Write frame: 0xAA, addr, data.  Read frame: 0xBB, addr; the read-back byte
// is handed to the UART transmitter once it is not busy.
//
// Ports:
//   CLK, RST        - clock (rising edge), synchronous active-high reset
//   i_RX_Data/Valid - received byte and its one-cycle valid pulse
//   o_WrData        - register-file write data (held between strobes)
//   o_Address       - register-file address (held between strobes)
//   o_WrEn, o_RdEn  - one-cycle register-file write/read strobes
//   i_RdData/Valid  - register-file read data and its valid
//   o_TX_Data/Valid - byte for the transmitter and its one-cycle pulse
//   i_TX_Busy       - transmitter busy, blocks o_TX_Valid while high
//   o_Cmd_Err       - one-cycle pulse on any rejected or aborted frame
//
// Optional build macro: REG_CMD_TIMEOUT_EN adds an inter-byte timeout of
// TIMEOUT_CYCLES clocks while a frame is partially received.
// ---------------------------------------------------------------------------
module reg_cmd_ctrl
  import reg_cmd_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    i_RX_Data,
  input  logic                     i_RX_Valid,
  output logic [DATA_WIDTH-1:0]    o_WrData,
  output logic [ADDRESS_WIDTH-1:0] o_Address,
  output logic                     o_WrEn,
  output logic                     o_RdEn,
  input  logic [DATA_WIDTH-1:0]    i_RdData,
  input  logic                     i_RdData_Valid,
  output logic [DATA_WIDTH-1:0]    o_TX_Data,
  output logic                     o_TX_Valid,
  input  logic                     i_TX_Busy,
  output logic                     o_Cmd_Err
);

  reg_cmd_state_e           state_q;
  logic [DATA_WIDTH-1:0]    wrData_q;
  logic [ADDRESS_WIDTH-1:0] address_q;
  logic                     wrEn_q;
  logic                     rdEn_q;
  logic [DATA_WIDTH-1:0]    txData_q;
  logic                     txValid_q;
  logic                     cmdErr_q;

`ifdef REG_CMD_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] timeoutCnt_q;
  logic            inFrame;
  logic            timeoutHit;

  // Only the states that wait for the next byte of a frame are timed.
  assign inFrame    = (state_q == WR_ADDR) || (state_q == WR_DATA) ||
                      (state_q == RD_ADDR);
  assign timeoutHit = inFrame && !i_RX_Valid && (timeoutCnt_q == CntLast);
`endif

  // Whole sequencer in one registered block: every output is a flop, the
  // strobes default low each cycle so they can only ever last one cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      wrData_q  <= '0;
      address_q <= '0;
      wrEn_q    <= 1'b0;
      rdEn_q    <= 1'b0;
      txData_q  <= '0;
      txValid_q <= 1'b0;
      cmdErr_q  <= 1'b0;
`ifdef REG_CMD_TIMEOUT_EN
      timeoutCnt_q <= '0;
`endif
    end else begin
      wrEn_q    <= 1'b0;
      rdEn_q    <= 1'b0;
      txValid_q <= 1'b0;
      cmdErr_q  <= 1'b0;

      case (state_q)
        IDLE: begin
          if (i_RX_Valid) begin
            if (i_RX_Data == CMD_WRITE) begin
              state_q <= WR_ADDR;
            end else if (i_RX_Data == CMD_READ) begin
              state_q <= RD_ADDR;
            end else begin
              cmdErr_q <= 1'b1;
            end
          end
        end

        WR_ADDR, RD_ADDR: begin
          if (i_RX_Valid) begin
            if (addrByteOk(i_RX_Data)) begin
              address_q <= i_RX_Data[ADDRESS_WIDTH-1:0];
              if (state_q == WR_ADDR) begin
                state_q <= WR_DATA;
              end else begin
                rdEn_q  <= 1'b1;
                state_q <= RD_WAIT;
              end
            end else begin
              cmdErr_q <= 1'b1;
              state_q  <= IDLE;
            end
          end
        end

        WR_DATA: begin
          if (i_RX_Valid) begin
            wrData_q <= i_RX_Data;
            wrEn_q   <= 1'b1;
            state_q  <= IDLE;
          end
        end

        // Read data with an idle transmitter goes straight out, which keeps
        // the read-to-TX latency at one cycle after the data arrives.
        RD_WAIT: begin
          if (i_RX_Valid) begin
            cmdErr_q <= 1'b1;
          end
          if (i_RdData_Valid) begin
            txData_q <= i_RdData;
            if (!i_TX_Busy) begin
              txValid_q <= 1'b1;
              state_q   <= IDLE;
            end else begin
              state_q <= TX_SEND;
            end
          end
        end

        TX_SEND: begin
          if (i_RX_Valid) begin
            cmdErr_q <= 1'b1;
          end
          if (!i_TX_Busy) begin
            txValid_q <= 1'b1;
            state_q   <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase

`ifdef REG_CMD_TIMEOUT_EN
      // The counter restarts on every byte and is parked at zero outside a
      // frame, so it is already clear on entry to any timed state.
      if (timeoutHit) begin
        cmdErr_q <= 1'b1;
        state_q  <= IDLE;
      end
      if (!inFrame || i_RX_Valid || timeoutHit) begin
        timeoutCnt_q <= '0;
      end else begin
        timeoutCnt_q <= timeoutCnt_q + 1'b1;
      end
`endif
    end
  end

  assign o_WrData   = wrData_q;
  assign o_Address  = address_q;
  assign o_WrEn     = wrEn_q;
  assign o_RdEn     = rdEn_q;
  assign o_TX_Data  = txData_q;
  assign o_TX_Valid = txValid_q;
  assign o_Cmd_Err  = cmdErr_q;

endmodule
